// File: rtl/alu_pkg.sv
// Shared encodings for the sequential N-bit ALU: operation select codes and
// the multiplier control states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

endpackage

// File: rtl/shift_add_mult.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH
// steps per operation. done/product are valid on the final step's clock.
module shift_add_mult
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_step;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign busy     = (state_q == S_MUL);
  // done marks the clock edge that performs the last step, so the product
  // is taken from the combinational step result rather than acc_q.
  assign done     = busy && (cnt_q == CW'(1));
  assign product  = acc_step;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= CW'(WIDTH);
      end else if (busy) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/top_nbit_alu_seq.sv
// Button-driven N-bit calculator: operand registers, button edge detection,
// single-cycle add/sub and a multi-cycle multiply feeding one result register.
module top_nbit_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic                 btnLoadA,
  input  logic                 btnLoadB,
  input  logic                 btnStart,
  input  logic [1:0]           op,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry_borrow,
  output logic                 busy,
  output logic                 done
);

  logic [WIDTH-1:0]   reg_a, reg_b;
  logic               load_a_q, load_b_q, start_q;
  logic               load_a_e, load_b_e, start_e;
  logic               accept, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] res_d;
  logic               cb_d, wr;

  assign load_a_e  = btnLoadA & ~load_a_q;
  assign load_b_e  = btnLoadB & ~load_b_q;
  assign start_e   = btnStart & ~start_q;
  assign accept    = start_e & ~mul_busy;
  assign mul_start = accept && (op == OP_MUL);
  assign busy      = mul_busy;

  assign sum  = {1'b0, reg_a} + {1'b0, reg_b};
  assign diff = {1'b0, reg_a} - {1'b0, reg_b};

  shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (reg_a),
    .b       (reg_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // mul_done only occurs while busy and accept only while idle, so the two
  // write sources never compete.
  always_comb begin
    res_d = result;
    cb_d  = carry_borrow;
    wr    = 1'b0;
    if (mul_done) begin
      res_d = mul_product;
      cb_d  = |mul_product[2*WIDTH-1:WIDTH];
      wr    = 1'b1;
    end else if (accept) begin
      case (op)
        OP_ADD: begin
          res_d = {{(WIDTH-1){1'b0}}, sum};
          cb_d  = sum[WIDTH];
          wr    = 1'b1;
        end
        OP_SUB: begin
          res_d = {{(WIDTH-1){diff[WIDTH]}}, diff};
          cb_d  = (reg_a < reg_b);
          wr    = 1'b1;
        end
        OP_RSV: begin
          res_d = '0;
          cb_d  = 1'b0;
          wr    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      start_q      <= 1'b0;
      reg_a        <= '0;
      reg_b        <= '0;
      result       <= '0;
      carry_borrow <= 1'b0;
      done         <= 1'b0;
    end else begin
      load_a_q     <= btnLoadA;
      load_b_q     <= btnLoadB;
      start_q      <= btnStart;
      if (load_a_e && !mul_busy) reg_a <= inA;
      if (load_b_e && !mul_busy) reg_b <= inB;
      result       <= res_d;
      carry_borrow <= cb_d;
      done         <= wr;
    end
  end

endmodule

// File: tb/tb_top_nbit_alu_seq.sv
// Scoreboard bench for top_nbit_alu_seq at WIDTH=4: expected results are
// queued when a start is driven and compared when done pulses.
module tb_top_nbit_alu_seq;

  localparam int W = 4;

  logic           clk, rst;
  logic [W-1:0]   inA, inB;
  logic           btnLoadA, btnLoadB, btnStart;
  logic [1:0]     op;
  logic [2*W-1:0] result;
  logic           carry_borrow, busy, done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int mA = 0, mB = 0;
  logic [8:0] sb[$];

  top_nbit_alu_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .inA          (inA),
    .inB          (inB),
    .btnLoadA     (btnLoadA),
    .btnLoadB     (btnLoadB),
    .btnStart     (btnStart),
    .op           (op),
    .result       (result),
    .carry_borrow (carry_borrow),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers: {carry_borrow, result[7:0]}.
  function automatic logic [8:0] calc(input int o, input int a, input int b);
    int r;
    logic c;
    case (o)
      0:       begin r = a + b; c = (r > 15); end
      1:       begin r = a - b; c = (a < b);  end
      2:       begin r = a * b; c = (r > 15); end
      default: begin r = 0;     c = 1'b0;     end
    endcase
    return {c, r[7:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (done) begin
      done_seen++;
      check_eq("busy_with_done", {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check_eq("result", {24'b0, result}, {24'b0, e[7:0]});
        check_eq("carry_borrow", {31'b0, carry_borrow}, {31'b0, e[8]});
      end
    end
  end

  task automatic load_ab(input int a, input int b);
    @(negedge clk);
    inA = W'(a); inB = W'(b); btnLoadA = 1'b1; btnLoadB = 1'b1;
    mA = a; mB = b;
    @(negedge clk);
    btnLoadA = 1'b0; btnLoadB = 1'b0;
  endtask

  // Returns at the negedge following the start edge.
  task automatic start_op(input int o);
    @(negedge clk);
    op = 2'(o); btnStart = 1'b1;
    sb.push_back(calc(o, mA, mB));
    @(negedge clk);
    btnStart = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int bc, d0;
    bit got_done;
    rst = 1'b1; inA = '0; inB = '0; op = '0;
    btnLoadA = 1'b0; btnLoadB = 1'b0; btnStart = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_result", {24'b0, result}, 32'd0);
    check_eq("rst_carry", {31'b0, carry_borrow}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Add with carry out
    load_ab(10, 11);
    start_op(0);
    check_eq("add_busy", {31'b0, busy}, 32'd0);
    wait_idle();

    // Subtraction, both signs
    load_ab(5, 9);  start_op(1); wait_idle();
    load_ab(9, 5);  start_op(1); wait_idle();
    load_ab(7, 7);  start_op(1); wait_idle();

    // Reserved op clears result
    start_op(3); wait_idle();

    // Multiply 15*15 with latency count
    load_ab(15, 15);
    start_op(2);
    bc = 0; got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got_done = 1'b1; break; end
      if (busy) bc++;
      @(negedge clk);
    end
    check_eq("mul_done_seen", {31'b0, got_done}, 32'd1);
    check_eq("mul_busy_cycles", bc, 32'd4);
    wait_idle();

    // Multiply with load/start/op interference while busy
    load_ab(3, 2);
    d0 = done_seen;
    start_op(2);
    inA = 4'd7; btnLoadA = 1'b1;
    @(negedge clk);
    btnLoadA = 1'b0; btnStart = 1'b1;
    @(negedge clk);
    btnStart = 1'b0; op = 2'b00;
    wait_idle();
    repeat (3) @(negedge clk);
    check_eq("interfere_done_count", done_seen - d0, 32'd1);
    start_op(0);                      // regA must still be 3: 3+2
    wait_idle();

    // Reset in the second busy cycle of a multiply
    load_ab(15, 15);
    start_op(2);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check_eq("midrst_result", {24'b0, result}, 32'd0);
    check_eq("midrst_carry", {31'b0, carry_borrow}, 32'd0);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_done", {31'b0, done}, 32'd0);
    mA = 0; mB = 0;
    @(negedge clk);
    rst = 1'b0;
    start_op(0);                      // registers cleared: 0+0
    wait_idle();

    // Held start button yields exactly one operation
    load_ab(1, 1);
    d0 = done_seen;
    @(negedge clk);
    op = 2'b00; btnStart = 1'b1;
    sb.push_back(calc(0, mA, mB));
    repeat (10) @(negedge clk);
    btnStart = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check_eq("held_done_count", done_seen - d0, 32'd1);

    // Same-edge load and start uses the old A
    @(negedge clk);
    inA = 4'd4; btnLoadA = 1'b1; op = 2'b00; btnStart = 1'b1;
    sb.push_back(calc(0, mA, mB));
    mA = 4;
    @(negedge clk);
    btnLoadA = 1'b0; btnStart = 1'b0;
    wait_idle();
    start_op(0);                      // new A visible: 4+1
    wait_idle();

    // Small multiply without overflow
    load_ab(3, 5); start_op(2); wait_idle();

    repeat (3) @(negedge clk);
    check_eq("queue_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
